// File: rtl/ram_loader_pkg.sv
// Shared types for the stream-to-RAM table loader.
// Holds the loader FSM state encoding.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/sp_ram_rf.sv
// Single-port-write RAM with a registered, read-first read port.
// Contents are never cleared; only the read register resets.
module sp_ram_rf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the array yields the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_loader.sv
// Loads a burst of stream words into an on-chip RAM that
// consumers read with ROM-style one-cycle registered timing.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_R = 1;
  localparam logic [ADDR_WIDTH:0]   ZERO_R = '0;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic                  w_load;
  logic                  w_we;

  assign w_load   = (r_state == LOAD);
  assign w_we     = w_load && wr_valid;
  assign wr_ready = w_load;
  assign busy     = w_load;
  assign done     = (r_state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_waddr <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_waddr <= base_addr;
            r_rem   <= len;
            r_state <= (len == ZERO_R) ? FIN : LOAD;
          end
        end
        LOAD: begin
          if (w_we) begin
            r_waddr <= r_waddr + ONE_A;
            r_rem   <= r_rem - ONE_R;
            if (r_rem == ONE_R) begin
              r_state <= FIN;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sp_ram_rf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_rst  (rst),
    .i_we   (w_we),
    .i_waddr(r_waddr),
    .i_wdata(wr_data),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: bursts, stalls, wrap,
// zero length, read-first collision, ignored start, reset abort.
module tb_ram_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  int n_vec;
  int n_miss;
  int n_done;
  int n_rdy;

  ram_loader #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (wr_ready) n_rdy++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] b, input logic [8:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic load1(input logic [7:0] a, input logic [7:0] d);
    go(a, 9'd1);
    send(d);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    n_done = 0;
    n_rdy = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_addr = '0;

    // reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, wr_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rd_data}, 32'd0);
    tick();
    rst = 1'b0;

    // known background words
    load1(8'h14, 8'h5C);
    load1(8'h20, 8'h11);
    load1(8'h80, 8'h99);
    load1(8'h01, 8'h77);

    // basic burst
    n_done = 0;
    go(8'h10, 9'd4);
    chk("b_busy", {31'd0, busy}, 32'd1);
    chk("b_rdy", {31'd0, wr_ready}, 32'd1);
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    chk("b_done_early", {31'd0, done}, 32'd0);
    send(8'hA4);
    chk("b_done", {31'd0, done}, 32'd1);
    chk("b_fin_busy", {31'd0, busy}, 32'd0);
    chk("b_fin_rdy", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("b_done_off", {31'd0, done}, 32'd0);
    chk("b_done_cnt", n_done, 32'd1);
    rd("b_rd10", 8'h10, 8'hA1);
    rd("b_rd11", 8'h11, 8'hA2);
    rd("b_rd12", 8'h12, 8'hA3);
    rd("b_rd13", 8'h13, 8'hA4);
    rd("b_rd14", 8'h14, 8'h5C);

    // stalled burst
    n_done = 0;
    go(8'h30, 9'd4);
    for (int i = 0; i < 4; i++) begin
      send(8'hB1 + 8'(i));
      if (i < 3) begin
        for (int s = 0; s < 3; s++) begin
          chk("s_rdy", {31'd0, wr_ready}, 32'd1);
          tick();
        end
      end
    end
    chk("s_done", {31'd0, done}, 32'd1);
    tick();
    tick();
    chk("s_done_cnt", n_done, 32'd1);
    rd("s_rd30", 8'h30, 8'hB1);
    rd("s_rd31", 8'h31, 8'hB2);
    rd("s_rd32", 8'h32, 8'hB3);
    rd("s_rd33", 8'h33, 8'hB4);

    // wrap
    go(8'hFE, 9'd3);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    tick();
    rd("w_rdFE", 8'hFE, 8'h01);
    rd("w_rdFF", 8'hFF, 8'h02);
    rd("w_rd00", 8'h00, 8'h03);
    rd("w_rd01", 8'h01, 8'h77);

    // zero length
    n_done = 0;
    n_rdy = 0;
    start = 1'b1;
    base_addr = 8'h10;
    len = 9'd0;
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    chk("z_done_pre", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("z_done", {31'd0, done}, 32'd1);
    tick();
    chk("z_done_off", {31'd0, done}, 32'd0);
    wr_valid = 1'b0;
    tick();
    chk("z_rdy_cnt", n_rdy, 32'd0);
    chk("z_done_cnt", n_done, 32'd1);
    rd("z_rd10", 8'h10, 8'hA1);

    // read-first collision
    go(8'h20, 9'd1);
    rd_addr = 8'h20;
    send(8'h55);
    chk("c_old", {24'd0, rd_data}, 32'h11);
    tick();
    chk("c_new", {24'd0, rd_data}, 32'h55);

    // start ignored mid-burst
    n_done = 0;
    go(8'h40, 9'd3);
    send(8'hC1);
    start = 1'b1;
    base_addr = 8'h80;
    len = 9'd2;
    send(8'hC2);
    start = 1'b0;
    chk("i_busy", {31'd0, busy}, 32'd1);
    send(8'hC3);
    chk("i_done", {31'd0, done}, 32'd1);
    tick();
    tick();
    chk("i_idle", {31'd0, busy}, 32'd0);
    chk("i_done_cnt", n_done, 32'd1);
    rd("i_rd40", 8'h40, 8'hC1);
    rd("i_rd41", 8'h41, 8'hC2);
    rd("i_rd42", 8'h42, 8'hC3);
    rd("i_rd80", 8'h80, 8'h99);

    // reset mid-burst
    n_done = 0;
    go(8'h50, 9'd5);
    send(8'hD1);
    send(8'hD2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_rdy", {31'd0, wr_ready}, 32'd0);
    tick();
    tick();
    chk("r_done_cnt", n_done, 32'd0);
    rd("r_rd50", 8'h50, 8'hD1);
    rd("r_rd51", 8'h51, 8'hD2);
    go(8'h60, 9'd1);
    chk("r_restart", {31'd0, busy}, 32'd1);
    send(8'hE1);
    chk("r_done2", {31'd0, done}, 32'd1);
    tick();
    rd("r_rd60", 8'h60, 8'hE1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
